// File: rtl/cv32e40p_tmr_voter_monitor.sv
// cv32e40p_tmr_voter_monitor
// Majority-of-3 voter for N_IN triplets of LEN-bit words with per-replica
// fault identification, saturating error statistics and persistent-fault
// flags. The vote path is registered (PIPE=1, latency 1) or combinational
// (PIPE=0). Statistics and persistent flags are always registered.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   valid_i             input triplets valid this cycle
//   clear_i             clear counters, streaks and persistent flags
//   in_1_i/in_2_i/in_3_i  replica words, packed [N_IN-1:0][LEN-1:0]
//   valid_o             vote outputs valid
//   voted_o             voted words
//   err_corrected_o     single-replica mismatch corrected, per triplet
//   err_detected_o      any mismatch, per triplet
//   faulty_rep_o        outvoted replica per triplet (0 = none, 1..3)
//   corr_cnt_o          cycles with at least one corrected triplet
//   uncorr_cnt_o        cycles with at least one all-different triplet
//   persistent_fault_o  sticky per-replica flag, bit r-1 = replica r
module cv32e40p_tmr_voter_monitor #(
  parameter int unsigned LEN        = 32,
  parameter int unsigned N_IN       = 1,
  parameter int unsigned PIPE       = 1,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned PERSIST_TH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           valid_i,
  input  logic                           clear_i,
  input  logic [N_IN-1:0][LEN-1:0]       in_1_i,
  input  logic [N_IN-1:0][LEN-1:0]       in_2_i,
  input  logic [N_IN-1:0][LEN-1:0]       in_3_i,
  output logic                           valid_o,
  output logic [N_IN-1:0][LEN-1:0]       voted_o,
  output logic [N_IN-1:0]                err_corrected_o,
  output logic [N_IN-1:0]                err_detected_o,
  output logic [N_IN-1:0][1:0]           faulty_rep_o,
  output logic [CNT_W-1:0]               corr_cnt_o,
  output logic [CNT_W-1:0]               uncorr_cnt_o,
  output logic [2:0]                     persistent_fault_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [7:0]       TH      = 8'(PERSIST_TH);

  typedef struct packed {
    logic [LEN-1:0] word;
    logic           corr;
    logic           det;
    logic [1:0]     rep;
  } vote_t;

  // Word-level 2-of-3 vote; the three pairwise compares select the outcome.
  function automatic vote_t vote3(input logic [LEN-1:0] a,
                                  input logic [LEN-1:0] b,
                                  input logic [LEN-1:0] c);
    vote_t r;
    logic  e12, e13, e23;
    e12 = (a == b);
    e13 = (a == c);
    e23 = (b == c);
    case ({e12, e13, e23})
      3'b111:  r = '{word: a, corr: 1'b0, det: 1'b0, rep: 2'd0};
      3'b001:  r = '{word: b, corr: 1'b1, det: 1'b1, rep: 2'd1};
      3'b010:  r = '{word: a, corr: 1'b1, det: 1'b1, rep: 2'd2};
      3'b100:  r = '{word: a, corr: 1'b1, det: 1'b1, rep: 2'd3};
      default: r = '{word: a, corr: 1'b0, det: 1'b1, rep: 2'd0};
    endcase
    return r;
  endfunction

  vote_t             vote_res [N_IN];
  logic              any_corr;
  logic              any_uncorr;
  logic [2:0]        outvoted;
  logic [2:0][7:0]   streak;
  logic [2:0]        streak_hit;

  // Vote every triplet of the current inputs.
  always_comb begin
    for (int i = 0; i < int'(N_IN); i++) begin
      vote_res[i] = vote3(in_1_i[i], in_2_i[i], in_3_i[i]);
    end
  end

  // Reduce per-triplet results to per-cycle events for the statistics.
  always_comb begin
    any_corr   = 1'b0;
    any_uncorr = 1'b0;
    outvoted   = 3'b000;
    for (int i = 0; i < int'(N_IN); i++) begin
      if (vote_res[i].corr) begin
        any_corr = 1'b1;
      end else begin
        any_uncorr = any_uncorr | vote_res[i].det;
      end
      for (int k = 0; k < 3; k++) begin
        if (vote_res[i].rep == 2'(k + 1)) begin
          outvoted[k] = 1'b1;
        end else begin
          outvoted[k] = outvoted[k];
        end
      end
    end
  end

  generate
    if (PIPE != 0) begin : g_pipe
      logic                     valid_q;
      logic [N_IN-1:0][LEN-1:0] voted_q;
      logic [N_IN-1:0]          corr_q;
      logic [N_IN-1:0]          det_q;
      logic [N_IN-1:0][1:0]     rep_q;

      // Vote result register; data holds while no valid triplets arrive.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= 1'b0;
          voted_q <= '0;
          corr_q  <= '0;
          det_q   <= '0;
          rep_q   <= '0;
        end else begin
          valid_q <= valid_i;
          if (valid_i) begin
            for (int i = 0; i < int'(N_IN); i++) begin
              voted_q[i] <= vote_res[i].word;
              corr_q[i]  <= vote_res[i].corr;
              det_q[i]   <= vote_res[i].det;
              rep_q[i]   <= vote_res[i].rep;
            end
          end
        end
      end

      assign valid_o         = valid_q;
      assign voted_o         = voted_q;
      assign err_corrected_o = corr_q;
      assign err_detected_o  = det_q;
      assign faulty_rep_o    = rep_q;
    end else begin : g_comb
      // Combinational vote outputs straight from the current inputs.
      always_comb begin
        valid_o = valid_i;
        for (int i = 0; i < int'(N_IN); i++) begin
          voted_o[i]         = vote_res[i].word;
          err_corrected_o[i] = vote_res[i].corr;
          err_detected_o[i]  = vote_res[i].det;
          faulty_rep_o[i]    = vote_res[i].rep;
        end
      end
    end
  endgenerate

  // Saturating event counters and per-replica outvoted streaks.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      corr_cnt_o   <= '0;
      uncorr_cnt_o <= '0;
      streak       <= '0;
    end else if (valid_i) begin
      if (any_corr && (corr_cnt_o != CNT_MAX)) begin
        corr_cnt_o <= corr_cnt_o + CNT_W'(1);
      end
      if (any_uncorr && (uncorr_cnt_o != CNT_MAX)) begin
        uncorr_cnt_o <= uncorr_cnt_o + CNT_W'(1);
      end
      for (int k = 0; k < 3; k++) begin
        if (!outvoted[k]) begin
          streak[k] <= 8'd0;
        end else if (streak[k] < TH) begin
          streak[k] <= streak[k] + 8'd1;
        end else begin
          streak[k] <= TH;
        end
      end
    end
  end

  // A streak that has reached the threshold raises its flag one cycle later.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      streak_hit[k] = (streak[k] == TH);
    end
  end

  // Sticky persistent-fault flags.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      persistent_fault_o <= 3'b000;
    end else begin
      persistent_fault_o <= persistent_fault_o | streak_hit;
    end
  end

endmodule

// File: tb/tb_cv32e40p_tmr_voter_monitor.sv
// Self-checking bench: DUT A (N_IN=2, PIPE=1, CNT_W=3, TH=4) and
// DUT B (N_IN=1, PIPE=0, CNT_W=4, TH=2) share one stimulus stream; B sees
// triplet 0 only. Expected values come from a behavioural model.
module tb_cv32e40p_tmr_voter_monitor;

  logic clk = 1'b0;
  logic rst, valid, clear;
  logic [1:0][31:0] a1, a2, a3;

  logic             va;
  logic [1:0][31:0] vot_a;
  logic [1:0]       corr_a, det_a;
  logic [1:0][1:0]  rep_a;
  logic [2:0]       ccnt_a, ucnt_a, pers_a;

  logic             vb;
  logic [31:0]      vot_b;
  logic             corr_b, det_b;
  logic [1:0]       rep_b;
  logic [3:0]       ccnt_b, ucnt_b;
  logic [2:0]       pers_b;

  int npass = 0;
  int ntotal = 0;

  // model state, index 0 = DUT A, 1 = DUT B
  int         m_corr [2];
  int         m_unc  [2];
  int         m_streak [2][3];
  logic [2:0] m_pers [2];
  int         cmax [2] = '{7, 15};
  int         thv  [2] = '{4, 2};
  int         nin  [2] = '{2, 1};

  logic        e_valid;
  logic [31:0] e_vot [2];
  logic        e_corr [2];
  logic        e_det [2];
  logic [1:0]  e_rep [2];

  always #5 clk = ~clk;

  cv32e40p_tmr_voter_monitor #(.LEN(32), .N_IN(2), .PIPE(1), .CNT_W(3), .PERSIST_TH(4)) dut_a (
    .clk(clk), .rst(rst), .valid_i(valid), .clear_i(clear),
    .in_1_i(a1), .in_2_i(a2), .in_3_i(a3),
    .valid_o(va), .voted_o(vot_a), .err_corrected_o(corr_a), .err_detected_o(det_a),
    .faulty_rep_o(rep_a), .corr_cnt_o(ccnt_a), .uncorr_cnt_o(ucnt_a),
    .persistent_fault_o(pers_a)
  );

  cv32e40p_tmr_voter_monitor #(.LEN(32), .N_IN(1), .PIPE(0), .CNT_W(4), .PERSIST_TH(2)) dut_b (
    .clk(clk), .rst(rst), .valid_i(valid), .clear_i(clear),
    .in_1_i(a1[0]), .in_2_i(a2[0]), .in_3_i(a3[0]),
    .valid_o(vb), .voted_o(vot_b), .err_corrected_o(corr_b), .err_detected_o(det_b),
    .faulty_rep_o(rep_b), .corr_cnt_o(ccnt_b), .uncorr_cnt_o(ucnt_b),
    .persistent_fault_o(pers_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntotal++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end else begin
      npass++;
    end
  endtask

  // Reference vote: count how many replicas agree with each one.
  function automatic void ref_vote(input logic [31:0] x1, x2, x3,
                                   output logic [31:0] w, output logic c, d,
                                   output logic [1:0] rep);
    logic [31:0] v [3];
    int          m [3];
    v = '{x1, x2, x3};
    for (int r = 0; r < 3; r++) begin
      m[r] = 0;
      for (int j = 0; j < 3; j++) if (v[j] == v[r]) m[r]++;
    end
    w = x1; c = 1'b0; d = 1'b0; rep = 2'd0;
    if (m[0] != 3) begin
      d = 1'b1;
      for (int r = 0; r < 3; r++) begin
        if (m[r] == 1 && m[(r + 1) % 3] == 2) begin
          c = 1'b1;
          rep = 2'(r + 1);
          w = v[(r + 1) % 3];
        end
      end
    end
  endfunction

  task automatic model_edge();
    logic [31:0] w;
    logic        c, dd;
    logic [1:0]  rp;
    logic [2:0]  hit, ov;
    bit          ac, au;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_corr[d] = 0; m_unc[d] = 0; m_pers[d] = 3'b000;
        for (int k = 0; k < 3; k++) m_streak[d][k] = 0;
      end else begin
        for (int k = 0; k < 3; k++) hit[k] = (m_streak[d][k] == thv[d]);
        if (clear) begin
          m_corr[d] = 0; m_unc[d] = 0; m_pers[d] = 3'b000;
          for (int k = 0; k < 3; k++) m_streak[d][k] = 0;
        end else begin
          m_pers[d] = m_pers[d] | hit;
          if (valid) begin
            ac = 0; au = 0; ov = 3'b000;
            for (int t = 0; t < nin[d]; t++) begin
              ref_vote(a1[t], a2[t], a3[t], w, c, dd, rp);
              if (c) ac = 1;
              if (dd && !c) au = 1;
              if (rp != 2'd0) ov[rp - 2'd1] = 1'b1;
            end
            if (ac && m_corr[d] < cmax[d]) m_corr[d]++;
            if (au && m_unc[d] < cmax[d]) m_unc[d]++;
            for (int k = 0; k < 3; k++)
              m_streak[d][k] = ov[k] ? ((m_streak[d][k] + 1 > thv[d]) ? thv[d] : m_streak[d][k] + 1) : 0;
          end
        end
      end
    end
    if (rst) begin
      e_valid = 1'b0;
      for (int t = 0; t < 2; t++) begin
        e_vot[t] = '0; e_corr[t] = 1'b0; e_det[t] = 1'b0; e_rep[t] = 2'd0;
      end
    end else begin
      e_valid = valid;
      if (valid) begin
        for (int t = 0; t < 2; t++) ref_vote(a1[t], a2[t], a3[t], e_vot[t], e_corr[t], e_det[t], e_rep[t]);
      end
    end
  endtask

  // One clock: drive controls, check B's combinational path, then check
  // everything registered after the edge.
  task automatic cyc(input bit v, input bit clr, input bit r);
    logic [31:0] w;
    logic        c, dd;
    logic [1:0]  rp;
    valid = v; clear = clr; rst = r;
    #1;
    ref_vote(a1[0], a2[0], a3[0], w, c, dd, rp);
    check("b_valid", 64'(vb), 64'(v));
    check("b_voted", 64'(vot_b), 64'(w));
    check("b_corr", 64'(corr_b), 64'(c));
    check("b_det", 64'(det_b), 64'(dd));
    check("b_rep", 64'(rep_b), 64'(rp));
    @(posedge clk);
    model_edge();
    #1;
    check("a_valid", 64'(va), 64'(e_valid));
    for (int t = 0; t < 2; t++) begin
      check($sformatf("a_voted%0d", t), 64'(vot_a[t]), 64'(e_vot[t]));
      check($sformatf("a_corr%0d", t), 64'(corr_a[t]), 64'(e_corr[t]));
      check($sformatf("a_det%0d", t), 64'(det_a[t]), 64'(e_det[t]));
      check($sformatf("a_rep%0d", t), 64'(rep_a[t]), 64'(e_rep[t]));
    end
    check("a_corr_cnt", 64'(ccnt_a), 64'(m_corr[0]));
    check("a_uncorr_cnt", 64'(ucnt_a), 64'(m_unc[0]));
    check("a_persist", 64'(pers_a), 64'(m_pers[0]));
    check("b_corr_cnt", 64'(ccnt_b), 64'(m_corr[1]));
    check("b_uncorr_cnt", 64'(ucnt_b), 64'(m_unc[1]));
    check("b_persist", 64'(pers_b), 64'(m_pers[1]));
  endtask

  // pat: 0 all equal, 1..3 that replica outvoted, 4 all different
  task automatic set_trip(input int t, input int pat, input logic [31:0] base);
    a1[t] = base; a2[t] = base; a3[t] = base;
    case (pat)
      1: a1[t] = base ^ 32'h8000_0001;
      2: a2[t] = base ^ 32'h0001_0000;
      3: a3[t] = base ^ 32'h0000_0100;
      4: begin a2[t] = base ^ 32'h1; a3[t] = base ^ 32'h2; end
      default: ;
    endcase
  endtask

  initial begin
    a1 = '0; a2 = '0; a3 = '0;
    valid = 1'b0; clear = 1'b0; rst = 1'b1;
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    check("rst_valid", 64'(va), 64'd0);

    // all equal
    set_trip(0, 0, 32'hDEAD_BEEF); set_trip(1, 0, 32'hDEAD_BEEF);
    cyc(1, 0, 0);
    check("eq_voted", 64'(vot_a[0]), 64'hDEAD_BEEF);
    check("eq_det", 64'(det_a), 64'd0);
    check("eq_corr_cnt", 64'(ccnt_a), 64'd0);

    // single fault in replica 2
    a1[0] = 32'h5; a2[0] = 32'h1; a3[0] = 32'h5;
    cyc(1, 0, 0);
    check("sf_voted", 64'(vot_a[0]), 64'h5);
    check("sf_rep", 64'(rep_a[0]), 64'd2);
    check("sf_corr_cnt", 64'(ccnt_a), 64'd1);

    // all different
    a1[0] = 32'hA; a2[0] = 32'hB; a3[0] = 32'hC;
    cyc(1, 0, 0);
    check("ad_voted", 64'(vot_a[0]), 64'hA);
    check("ad_rep", 64'(rep_a[0]), 64'd0);
    check("ad_uncorr_cnt", 64'(ucnt_a), 64'd1);

    // three outvoted cycles then a clean one: no flag
    cyc(0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      set_trip(0, 3, $urandom); set_trip(1, 0, $urandom);
      cyc(1, 0, 0);
      cyc(0, 0, 0);
    end
    set_trip(0, 0, $urandom);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    check("p3_persist", 64'(pers_a), 64'd0);

    // four outvoted cycles with gaps: replica 3 flagged
    for (int i = 0; i < 4; i++) begin
      set_trip(0, 3, $urandom);
      cyc(1, 0, 0);
      cyc(0, 0, 0);
    end
    cyc(0, 0, 0);
    check("p4_persist", 64'(pers_a), 64'b100);

    // saturation, then clear beats a simultaneous event
    cyc(0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      set_trip(0, 1, $urandom);
      cyc(1, 0, 0);
    end
    check("sat_corr_cnt", 64'(ccnt_a), 64'd7);
    cyc(1, 1, 0);
    check("clr_corr_cnt", 64'(ccnt_a), 64'd0);

    // reset mid-stream
    set_trip(0, 2, $urandom);
    cyc(1, 0, 0);
    check("mid_valid", 64'(va), 64'd1);
    cyc(1, 0, 1);
    check("mid_rst_valid", 64'(va), 64'd0);
    check("mid_rst_cnt", 64'(ccnt_a), 64'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      set_trip(0, int'($urandom_range(0, 4)), $urandom);
      set_trip(1, int'($urandom_range(0, 4)), $urandom);
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0, $urandom_range(0, 59) == 0);
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
